// File: rtl/ladybird_aclint_if.sv
// ladybird_aclint_if: valid/ready request/response bus between the core data
// port (master) and the ACLINT register block (slave).
interface ladybird_aclint_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/ladybird_aclint.sv
// ladybird_aclint: core-local interruptor (MSIP, MTIME, MTIMECMP) behind a
// single-outstanding valid/ready slave with one-cycle access latency.
// Optional feature macro: LADYBIRD_ACLINT_SSWI_EN enables the SETSSIP
// register at +0x8000 and the ssip_pulse output.
module ladybird_aclint #(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [31:0] BASEADDR = 32'h0200_0000
) (
    input  logic                clk,
    input  logic                rst,
    ladybird_aclint_if.slave    bus,
    output logic                msip,
    output logic                mtip,
    output logic                ssip_pulse
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_SETSSIP  = 16'h8000;
    localparam logic [15:0] OFF_MTIME_LO = 16'hbff8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hbffc;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          msip_q, msip_d;
    logic          mtip_q;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] presc_q, presc_d;

    logic [31:0]   offset;
    logic [15:0]   off;
    logic          aligned;
    logic          accept;
    logic          wr_en;
    logic          tick;
    logic [31:0]   rdata;

    // Byte-lane merge of write data into an existing 32-bit register half.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

    assign offset  = bus.req_addr - BASEADDR;
    assign off     = offset[15:0];
    assign aligned = (bus.req_addr[1:0] == 2'b00);
    assign accept  = (state_q == ST_IDLE) && bus.req_valid;
    assign wr_en   = accept && bus.req_we && aligned;
    assign tick    = (presc_q == PRESC_MAX);

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = resp_data_q;
    assign msip           = msip_q;
    assign mtip           = mtip_q;

    // Read mux: register state as seen in the accepting cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rdata = 32'h0;
        if (aligned) begin
            case (off)
                OFF_MSIP:     rdata = {31'b0, msip_q};
                OFF_CMP_LO:   rdata = mtimecmp_q[31:0];
                OFF_CMP_HI:   rdata = mtimecmp_q[63:32];
                OFF_MTIME_LO: rdata = mtime_q[31:0];
                OFF_MTIME_HI: rdata = mtime_q[63:32];
                default:      rdata = 32'h0;
            endcase
        end
    end

    // Handshake FSM next state and captured response data.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d     = ST_RESP;
                    resp_data_d = bus.req_we ? 32'h0 : rdata;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer advance and register writes; a MTIME write overrides that cycle's tick.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en) begin
            case (off)
                OFF_MSIP: begin
                    if (bus.req_wstrb[0]) msip_d = bus.req_wdata[0];
                end
                OFF_CMP_LO: mtimecmp_d[31:0] =
                    merge_bytes(mtimecmp_q[31:0], bus.req_wdata, bus.req_wstrb);
                OFF_CMP_HI: mtimecmp_d[63:32] =
                    merge_bytes(mtimecmp_q[63:32], bus.req_wdata, bus.req_wstrb);
                OFF_MTIME_LO: mtime_d = {mtime_q[63:32],
                    merge_bytes(mtime_q[31:0], bus.req_wdata, bus.req_wstrb)};
                OFF_MTIME_HI: mtime_d = {
                    merge_bytes(mtime_q[63:32], bus.req_wdata, bus.req_wstrb),
                    mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            resp_data_q <= 32'h0;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            msip_q      <= msip_d;
            mtip_q      <= (mtime_q >= mtimecmp_q);
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
        end
    end

`ifdef LADYBIRD_ACLINT_SSWI_EN
    logic ssip_q;

    // One-cycle supervisor software interrupt pulse after a SETSSIP write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ssip_q <= 1'b0;
        end else begin
            ssip_q <= wr_en && (off == OFF_SETSSIP) &&
                      bus.req_wstrb[0] && bus.req_wdata[0];
        end
    end

    assign ssip_pulse = ssip_q;
`else
    assign ssip_pulse = 1'b0;
`endif

endmodule
